// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state encoding, debug codes
// and parameter defaults.
package simon_pkg;

  localparam int DEFAULT_MAX_ROUNDS     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_DISP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_t;

  localparam logic [1:0] DBG_IDLE  = 2'b00;
  localparam logic [1:0] DBG_DISP  = 2'b01;
  localparam logic [1:0] DBG_WAIT  = 2'b10;
  localparam logic [1:0] DBG_CHECK = 2'b11;

  // GEN, WIN and LOSE share the idle code; only the player-visible phases get their own.
  function automatic logic [1:0] dbg_code(input state_t s);
    case (s)
      ST_DISP:  return DBG_DISP;
      ST_WAIT:  return DBG_WAIT;
      ST_CHECK: return DBG_CHECK;
      default:  return DBG_IDLE;
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == ST_GEN) || (s == ST_DISP) || (s == ST_WAIT) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Phase handshakes between the game controller (master) and the
// generator/display/entry/compare blocks it sequences (slave).
interface simon_game_ctrl_if;

  logic gen_start;
  logic gen_done;
  logic disp_start;
  logic disp_done;
  logic wait_start;
  logic wait_done;
  logic check_start;
  logic check_done;
  logic check_pass;

  modport master (
    output gen_start, disp_start, wait_start, check_start,
    input  gen_done, disp_done, wait_done, check_done, check_pass
  );

  modport slave (
    input  gen_start, disp_start, wait_start, check_start,
    output gen_done, disp_done, wait_done, check_done, check_pass
  );

endinterface

// File: rtl/simon_wait_timer.sv
// Player-entry timeout: 16-bit saturating counter, expires when it reaches
// TIMEOUT_CYCLES-1; TIMEOUT_CYCLES = 0 never expires.
module simon_wait_timer
  import simon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] LIMIT = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 16'd0;
    end else if (clear) begin
      count_reg <= 16'd0;
    end else if (count_en && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count_reg == LIMIT);

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game sequencer: walks GEN -> DISP -> WAIT -> CHECK per round and
// reports win/lose. Every output is registered from the next-state value.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_ROUNDS     = DEFAULT_MAX_ROUNDS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  simon_game_ctrl_if.master         hs,
  output logic [3:0]                round,
  output logic [1:0]                dbg_state,
  output logic                      game_win,
  output logic                      game_lose,
  output logic                      busy
);

  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

  state_t     state_reg, state_next;
  logic [3:0] round_reg, round_next;
  logic       start_q_reg;
  logic       start_rise;
  logic       timer_clear;
  logic       timer_expired;

  logic       gen_start_reg, disp_start_reg, wait_start_reg, check_start_reg;
  logic       win_reg, lose_reg, busy_reg;
  logic [1:0] dbg_reg;

  assign start_rise = start & ~start_q_reg;

  simon_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .count_en(state_reg == ST_WAIT),
    .expired (timer_expired)
  );

  always_comb begin
    state_next  = state_reg;
    round_next  = round_reg;
    timer_clear = 1'b0;
    case (state_reg)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start_rise) begin
          state_next = ST_GEN;
          round_next = 4'd0;
        end
      end
      ST_GEN:  if (hs.gen_done) state_next = ST_DISP;
      ST_DISP: begin
        if (hs.disp_done) begin
          state_next  = ST_WAIT;
          timer_clear = 1'b1;
        end
      end
      // A wait_done in the expiry cycle still counts as a valid entry.
      ST_WAIT: begin
        if (hs.wait_done)          state_next = ST_CHECK;
        else if (timer_expired)    state_next = ST_LOSE;
      end
      ST_CHECK: begin
        if (hs.check_done) begin
          if (!hs.check_pass) begin
            state_next = ST_LOSE;
          end else if (round_reg == LAST_ROUND) begin
            state_next = ST_WIN;
          end else begin
            state_next = ST_DISP;
            round_next = round_reg + 4'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // start_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      round_reg       <= 4'd0;
      start_q_reg     <= 1'b1;
      gen_start_reg   <= 1'b0;
      disp_start_reg  <= 1'b0;
      wait_start_reg  <= 1'b0;
      check_start_reg <= 1'b0;
      win_reg         <= 1'b0;
      lose_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      dbg_reg         <= DBG_IDLE;
    end else begin
      state_reg       <= state_next;
      round_reg       <= round_next;
      start_q_reg     <= start;
      gen_start_reg   <= (state_next == ST_GEN)   && (state_reg != ST_GEN);
      disp_start_reg  <= (state_next == ST_DISP)  && (state_reg != ST_DISP);
      wait_start_reg  <= (state_next == ST_WAIT)  && (state_reg != ST_WAIT);
      check_start_reg <= (state_next == ST_CHECK) && (state_reg != ST_CHECK);
      win_reg         <= (state_next == ST_WIN);
      lose_reg        <= (state_next == ST_LOSE);
      busy_reg        <= is_busy(state_next);
      dbg_reg         <= dbg_code(state_next);
    end
  end

  assign hs.gen_start   = gen_start_reg;
  assign hs.disp_start  = disp_start_reg;
  assign hs.wait_start  = wait_start_reg;
  assign hs.check_start = check_start_reg;
  assign round          = round_reg;
  assign dbg_state      = dbg_reg;
  assign game_win       = win_reg;
  assign game_lose      = lose_reg;
  assign busy           = busy_reg;

endmodule
